cache_fill_arbiter: RTL and testbench

Parametrised miss-service controller that lets the pipelined CPU's instruction cache and data cache share one pipelined, fixed-latency main memory. It accepts block-fill requests from both caches, arbitrates between them, streams one block per request from memory, and returns each word with a write strobe and word index. It drives per-channel stall outputs to the pipeline hazard logic. It replaces the single-cycle instruction and data memories used by the previous core generation.

---
 rtl/cache_fill_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_cache_fill_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_arbiter.sv
// -----------------------------------------------------------------------------
// cache_fill_arbiter
//
// Miss-service controller that shares one pipelined, fixed-latency main memory
// between the instruction cache and the data cache. It picks one pending miss
// (the D side wins ties) and issues the reads for that whole block, one address
// per cycle. It then writes each returned word into the owning cache's data
// array and writes the tag together with the last word.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   i_miss, i_miss_addr     I-cache miss request (level) and byte address
//   d_miss, d_miss_addr     D-cache miss request (level) and byte address
//   i_stall, d_stall        combinational stalls to the hazard unit
//   i_fill_we, d_fill_we    per-channel data-array word write strobe
//   i_tag_we, d_tag_we      per-channel tag/valid write, with the last word
//   fill_data               word being written (shared by both channels)
//   fill_word_idx           index of that word within the block
//   mem_en, mem_addr        memory read issue, one address per cycle
//   mem_data, mem_data_valid read return, in issue order, fixed latency
// -----------------------------------------------------------------------------
module cache_fill_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int BLOCK_WORDS = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_miss,
    input  logic [ADDR_W-1:0]              i_miss_addr,
    input  logic                           d_miss,
    input  logic [ADDR_W-1:0]              d_miss_addr,
    output logic                           i_stall,
    output logic                           d_stall,
    output logic                           i_fill_we,
    output logic                           d_fill_we,
    output logic                           i_tag_we,
    output logic                           d_tag_we,
    output logic [DATA_W-1:0]              fill_data,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word_idx,
    output logic                           mem_en,
    output logic [ADDR_W-1:0]              mem_addr,
    input  logic [DATA_W-1:0]              mem_data,
    input  logic                           mem_data_valid
);

    localparam int IDX_W = $clog2(BLOCK_WORDS);
    // Counters carry one extra bit so that "all BLOCK_WORDS done" is representable.
    localparam int CNT_W = IDX_W + 1;
    // A block spans 2*BLOCK_WORDS bytes, so the low IDX_W+1 address bits are the offset.
    localparam int OFF_W = IDX_W + 1;

    localparam logic [CNT_W-1:0]  BW_CNT     = CNT_W'(BLOCK_WORDS);
    localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(BLOCK_WORDS - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL_D = 2'd1,
        ST_FILL_I = 2'd2
    } state_e;

    state_e              state_q,         state_d;
    logic [ADDR_W-1:0]   base_q,          base_d;
    logic [CNT_W-1:0]    issue_cnt_q,     issue_cnt_d;
    logic [CNT_W-1:0]    recv_cnt_q,      recv_cnt_d;
    logic                mem_en_q,        mem_en_d;
    logic [ADDR_W-1:0]   mem_addr_q,      mem_addr_d;
    logic                i_fill_we_q,     i_fill_we_d;
    logic                d_fill_we_q,     d_fill_we_d;
    logic                i_tag_we_q,      i_tag_we_d;
    logic                d_tag_we_q,      d_tag_we_d;
    logic [DATA_W-1:0]   fill_data_q,     fill_data_d;
    logic [IDX_W-1:0]    fill_word_idx_q, fill_word_idx_d;

    logic [ADDR_W-1:0]   start_base;

    // D has priority; the chosen miss address is aligned down to its block.
    assign start_base = (d_miss ? d_miss_addr : i_miss_addr) & ALIGN_MASK;

    // NOTE: combinational blocks use blocking '=' and give every output a
    // default first, so no path leaves a signal unassigned (which would infer a latch).
    always_comb begin
        state_d         = state_q;
        base_d          = base_q;
        issue_cnt_d     = issue_cnt_q;
        recv_cnt_d      = recv_cnt_q;
        mem_en_d        = 1'b0;
        mem_addr_d      = mem_addr_q;
        i_fill_we_d     = 1'b0;
        d_fill_we_d     = 1'b0;
        i_tag_we_d      = 1'b0;
        d_tag_we_d      = 1'b0;
        fill_data_d     = fill_data_q;
        fill_word_idx_d = fill_word_idx_q;

        case (state_q)
            ST_IDLE: begin
                if (d_miss || i_miss) begin
                    state_d     = d_miss ? ST_FILL_D : ST_FILL_I;
                    base_d      = start_base;
                    recv_cnt_d  = '0;
                    // mem_en is registered, so word 0 is issued on the entry
                    // edge itself. That puts it on the bus in the first fill
                    // cycle, and the issue count starts at one.
                    mem_en_d    = 1'b1;
                    mem_addr_d  = start_base;
                    issue_cnt_d = CNT_W'(1);
                end
            end

            default: begin
                if (issue_cnt_q < BW_CNT) begin
                    mem_en_d    = 1'b1;
                    mem_addr_d  = base_q + ADDR_W'({issue_cnt_q, 1'b0});
                    issue_cnt_d = issue_cnt_q + 1'b1;
                end

                // Leave one cycle after the tag write: the whole block has
                // been received and nothing is left in flight for this fill.
                if (recv_cnt_q == BW_CNT) begin
                    state_d = ST_IDLE;
                end else if (mem_data_valid) begin
                    fill_data_d     = mem_data;
                    fill_word_idx_d = recv_cnt_q[IDX_W-1:0];
                    recv_cnt_d      = recv_cnt_q + 1'b1;
                    if (state_q == ST_FILL_D) begin
                        d_fill_we_d = 1'b1;
                        d_tag_we_d  = (recv_cnt_q == LAST_CNT);
                    end else begin
                        i_fill_we_d = 1'b1;
                        i_tag_we_d  = (recv_cnt_q == LAST_CNT);
                    end
                end
            end
        endcase
    end

    // NOTE: clocked state uses non-blocking '<=' so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            base_q          <= '0;
            issue_cnt_q     <= '0;
            recv_cnt_q      <= '0;
            mem_en_q        <= 1'b0;
            mem_addr_q      <= '0;
            i_fill_we_q     <= 1'b0;
            d_fill_we_q     <= 1'b0;
            i_tag_we_q      <= 1'b0;
            d_tag_we_q      <= 1'b0;
            fill_data_q     <= '0;
            fill_word_idx_q <= '0;
        end else begin
            state_q         <= state_d;
            base_q          <= base_d;
            issue_cnt_q     <= issue_cnt_d;
            recv_cnt_q      <= recv_cnt_d;
            mem_en_q        <= mem_en_d;
            mem_addr_q      <= mem_addr_d;
            i_fill_we_q     <= i_fill_we_d;
            d_fill_we_q     <= d_fill_we_d;
            i_tag_we_q      <= i_tag_we_d;
            d_tag_we_q      <= d_tag_we_d;
            fill_data_q     <= fill_data_d;
            fill_word_idx_q <= fill_word_idx_d;
        end
    end

    // The stalls stay combinational so a new miss freezes the pipeline in the
    // same cycle it is raised.
    assign i_stall = i_miss | (state_q == ST_FILL_I);
    assign d_stall = d_miss | (state_q == ST_FILL_D);

    assign mem_en        = mem_en_q;
    assign mem_addr      = mem_addr_q;
    assign i_fill_we     = i_fill_we_q;
    assign d_fill_we     = d_fill_we_q;
    assign i_tag_we      = i_tag_we_q;
    assign d_tag_we      = d_tag_we_q;
    assign fill_data     = fill_data_q;
    assign fill_word_idx = fill_word_idx_q;

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_fill_arbiter
//
// Main instance: BLOCK_WORDS=8 against a memory of latency 4. A block-level
// schedule model tracks it: a fill that starts on edge E issues word k in
// cycle E+1+k, writes it in cycle E+1+k+L and is idle again after
// E+BLOCK_WORDS+L. Two more instances (BLOCK_WORDS=4/L=1, BLOCK_WORDS=16/L=10)
// are checked by counting issues, writes and the tag cycle.
// -----------------------------------------------------------------------------
module tb_cache_fill_arbiter;

    localparam int BW  = 8;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory contents are a fixed function of the address.
    function automatic logic [15:0] memfn(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    // ---------------- main instance (BW=8, L=4) ----------------
    logic        i_miss, d_miss;
    logic [15:0] i_miss_addr, d_miss_addr;
    logic        i_stall, d_stall, i_fill_we, d_fill_we, i_tag_we, d_tag_we;
    logic [15:0] fill_data;
    logic [2:0]  fill_word_idx;
    logic        mem_en;
    logic [15:0] mem_addr, mem_data;
    logic        mem_data_valid;

    cache_fill_arbiter #(.ADDR_W(16), .DATA_W(16), .BLOCK_WORDS(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_miss(i_miss), .i_miss_addr(i_miss_addr),
        .d_miss(d_miss), .d_miss_addr(d_miss_addr),
        .i_stall(i_stall), .d_stall(d_stall),
        .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
        .i_tag_we(i_tag_we), .d_tag_we(d_tag_we),
        .fill_data(fill_data), .fill_word_idx(fill_word_idx),
        .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_data_valid(mem_data_valid)
    );

    // Memory: an issue seen in cycle c returns valid in cycle c+L-1, so the
    // registered write lands in cycle c+L. It is not reset with the DUT.
    logic [15:0] en_h8 = '0;
    logic [15:0] ad_h8 [0:15];
    always @(posedge clk) begin
        en_h8 <= {en_h8[14:0], mem_en};
        ad_h8[0] <= mem_addr;
        for (int i = 1; i < 16; i++) ad_h8[i] <= ad_h8[i-1];
    end
    assign mem_data_valid = en_h8[LAT-2];
    assign mem_data       = en_h8[LAT-2] ? memfn(ad_h8[LAT-2]) : 16'hDEAD;

    // ---------------- sweep instance BW=4, L=1 ----------------
    logic        s4_i_miss, s4_d_miss;
    logic [15:0] s4_i_miss_addr, s4_d_miss_addr;
    logic        s4_i_stall, s4_d_stall, s4_i_fill_we, s4_d_fill_we, s4_i_tag_we, s4_d_tag_we;
    logic [15:0] s4_fill_data;
    logic [1:0]  s4_fill_word_idx;
    logic        s4_mem_en;
    logic [15:0] s4_mem_addr, s4_mem_data;
    logic        s4_mem_data_valid;

    cache_fill_arbiter #(.ADDR_W(16), .DATA_W(16), .BLOCK_WORDS(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .i_miss(s4_i_miss), .i_miss_addr(s4_i_miss_addr),
        .d_miss(s4_d_miss), .d_miss_addr(s4_d_miss_addr),
        .i_stall(s4_i_stall), .d_stall(s4_d_stall),
        .i_fill_we(s4_i_fill_we), .d_fill_we(s4_d_fill_we),
        .i_tag_we(s4_i_tag_we), .d_tag_we(s4_d_tag_we),
        .fill_data(s4_fill_data), .fill_word_idx(s4_fill_word_idx),
        .mem_en(s4_mem_en), .mem_addr(s4_mem_addr),
        .mem_data(s4_mem_data), .mem_data_valid(s4_mem_data_valid)
    );

    // L=1: the return is valid in the same cycle as the issue.
    assign s4_mem_data_valid = s4_mem_en;
    assign s4_mem_data       = s4_mem_en ? memfn(s4_mem_addr) : 16'hDEAD;

    // ---------------- sweep instance BW=16, L=10 ----------------
    logic        s16_i_miss, s16_d_miss;
    logic [15:0] s16_i_miss_addr, s16_d_miss_addr;
    logic        s16_i_stall, s16_d_stall, s16_i_fill_we, s16_d_fill_we, s16_i_tag_we, s16_d_tag_we;
    logic [15:0] s16_fill_data;
    logic [3:0]  s16_fill_word_idx;
    logic        s16_mem_en;
    logic [15:0] s16_mem_addr, s16_mem_data;
    logic        s16_mem_data_valid;

    cache_fill_arbiter #(.ADDR_W(16), .DATA_W(16), .BLOCK_WORDS(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .i_miss(s16_i_miss), .i_miss_addr(s16_i_miss_addr),
        .d_miss(s16_d_miss), .d_miss_addr(s16_d_miss_addr),
        .i_stall(s16_i_stall), .d_stall(s16_d_stall),
        .i_fill_we(s16_i_fill_we), .d_fill_we(s16_d_fill_we),
        .i_tag_we(s16_i_tag_we), .d_tag_we(s16_d_tag_we),
        .fill_data(s16_fill_data), .fill_word_idx(s16_fill_word_idx),
        .mem_en(s16_mem_en), .mem_addr(s16_mem_addr),
        .mem_data(s16_mem_data), .mem_data_valid(s16_mem_data_valid)
    );

    logic [15:0] en_h16 = '0;
    logic [15:0] ad_h16 [0:15];
    always @(posedge clk) begin
        en_h16 <= {en_h16[14:0], s16_mem_en};
        ad_h16[0] <= s16_mem_addr;
        for (int i = 1; i < 16; i++) ad_h16[i] <= ad_h16[i-1];
    end
    assign s16_mem_data_valid = en_h16[8];
    assign s16_mem_data       = en_h16[8] ? memfn(ad_h16[8]) : 16'hDEAD;

    // ---------------- block-schedule model of the main instance ----------------
    bit          m_active = 1'b0;
    bit          m_is_i   = 1'b0;
    logic [15:0] m_base   = '0;
    int          m_j      = 0;     // 1-based cycle number within the current fill

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_j      <= 0;
        end else if (m_active) begin
            if (m_j == BW + LAT) begin
                m_active <= 1'b0;
                m_j      <= 0;
            end else begin
                m_j <= m_j + 1;
            end
        end else if (d_miss) begin
            m_active <= 1'b1;
            m_is_i   <= 1'b0;
            m_base   <= d_miss_addr - (d_miss_addr % 16'(2 * BW));
            m_j      <= 1;
        end else if (i_miss) begin
            m_active <= 1'b1;
            m_is_i   <= 1'b1;
            m_base   <= i_miss_addr - (i_miss_addr % 16'(2 * BW));
            m_j      <= 1;
        end
    end

    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            automatic bit exp_iss = m_active && (m_j <= BW);
            automatic bit exp_wr  = m_active && (m_j > LAT) && (m_j <= BW + LAT);
            automatic int k       = m_j - LAT - 1;
            check("mem_en", 32'(mem_en), 32'(exp_iss));
            if (exp_iss) check("mem_addr", 32'(mem_addr), 32'(16'(m_base + 16'(2 * (m_j - 1)))));
            check("i_fill_we", 32'(i_fill_we), 32'(exp_wr && m_is_i));
            check("d_fill_we", 32'(d_fill_we), 32'(exp_wr && !m_is_i));
            check("i_tag_we", 32'(i_tag_we), 32'(exp_wr && m_is_i && k == BW - 1));
            check("d_tag_we", 32'(d_tag_we), 32'(exp_wr && !m_is_i && k == BW - 1));
            if (exp_wr) begin
                check("fill_word_idx", 32'(fill_word_idx), 32'(k));
                check("fill_data", 32'(fill_data), 32'(memfn(16'(m_base + 16'(2 * k)))));
            end
            check("i_stall", 32'(i_stall), 32'(i_miss || (m_active && m_is_i)));
            check("d_stall", 32'(d_stall), 32'(d_miss || (m_active && !m_is_i)));
        end
    end

    // ---------------- directed stimulus ----------------
    int t0 = 0;

    // Returns at the falling edge inside cycle n of the current test.
    task automatic at_cycle(input int n);
        while (cyc < t0 + n) @(negedge clk);
    endtask

    task automatic start_test;
        @(negedge clk);
        #1;
        t0 = cyc;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stray;
        int s4_iss, s4_wr, s4_wrong, s4_tag, s4_last;
        int s16_iss, s16_wr, s16_wrong, s16_tag, s16_last;
        logic [15:0] s4_first, s16_first;

        rst_n = 1'b0;
        i_miss = 1'b1; i_miss_addr = '0; d_miss = 1'b0; d_miss_addr = '0;
        s4_i_miss = 1'b0; s4_i_miss_addr = '0; s4_d_miss = 1'b0; s4_d_miss_addr = '0;
        s16_i_miss = 1'b0; s16_i_miss_addr = '0; s16_d_miss = 1'b0; s16_d_miss_addr = '0;

        // Reset state: registered outputs zero, stalls follow the miss inputs.
        repeat (2) @(negedge clk);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_fill_data", 32'(fill_data), 32'd0);
        check("rst_fill_idx", 32'(fill_word_idx), 32'd0);
        check("rst_we", 32'({i_fill_we, d_fill_we, i_tag_we, d_tag_we}), 32'd0);
        check("rst_i_stall", 32'(i_stall), 32'd1);
        check("rst_d_stall", 32'(d_stall), 32'd0);
        i_miss = 1'b0;
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);

        // Single I miss.
        start_test();
        i_miss_addr = 16'h1236; i_miss = 1'b1;
        at_cycle(1);  check("t1_addr_first", 32'(mem_addr), 32'h1230);
        at_cycle(4);  check("t1_no_we_c4", 32'(i_fill_we), 32'd0);
        at_cycle(5);  check("t1_we_c5", 32'(i_fill_we), 32'd1);
                      check("t1_data_c5", 32'(fill_data), 32'h6A2E);
        at_cycle(8);  check("t1_addr_last", 32'(mem_addr), 32'h123E);
        at_cycle(9);  check("t1_en_off", 32'(mem_en), 32'd0);
        at_cycle(12); check("t1_tag", 32'(i_tag_we), 32'd1);
                      check("t1_idx7", 32'(fill_word_idx), 32'd7);
                      check("t1_stall", 32'(i_stall), 32'd1);
        #1 i_miss = 1'b0;
        at_cycle(16);

        // Simultaneous misses: D first, I issues at cycle 14.
        start_test();
        d_miss_addr = 16'h40A0; d_miss = 1'b1;
        i_miss_addr = 16'h0010; i_miss = 1'b1;
        #2;
        check("t2_stalls_c0", 32'({d_stall, i_stall}), 32'b11);
        at_cycle(1);  check("t2_d_addr", 32'(mem_addr), 32'h40A0);
        at_cycle(12); check("t2_d_tag", 32'(d_tag_we), 32'd1);
        #1 d_miss = 1'b0;
        at_cycle(13); check("t2_gap", 32'(mem_en), 32'd0);
        at_cycle(14); check("t2_i_en", 32'(mem_en), 32'd1);
                      check("t2_i_addr", 32'(mem_addr), 32'h0010);
        at_cycle(25); check("t2_i_tag", 32'(i_tag_we), 32'd1);
        #1 i_miss = 1'b0;
        at_cycle(29);

        // Alignment at the top of the address space.
        start_test();
        d_miss_addr = 16'hFFFF; d_miss = 1'b1;
        at_cycle(1);  check("t3_addr_first", 32'(mem_addr), 32'hFFF0);
        at_cycle(8);  check("t3_addr_last", 32'(mem_addr), 32'hFFFE);
        at_cycle(9);  check("t3_en_off", 32'(mem_en), 32'd0);
        at_cycle(12); check("t3_tag", 32'(d_tag_we), 32'd1);
        #1 d_miss = 1'b0;
        at_cycle(16);

        // Flush: I miss dropped at cycle 3, the fill still completes.
        start_test();
        i_miss_addr = 16'h2A48; i_miss = 1'b1;
        at_cycle(3);
        #1 i_miss = 1'b0;
        at_cycle(12); check("t4_tag", 32'(i_tag_we), 32'd1);
                      check("t4_stall_c12", 32'(i_stall), 32'd1);
        at_cycle(13); check("t4_stall_c13", 32'(i_stall), 32'd0);
        at_cycle(16);

        // Reset mid-fill while memory keeps returning data.
        start_test();
        i_miss_addr = 16'h0A5E; i_miss = 1'b1;
        at_cycle(6);
        #1 rst_n = 1'b0; i_miss = 1'b0;
        #1;
        check("t5_rst_en", 32'(mem_en), 32'd0);
        check("t5_rst_addr", 32'(mem_addr), 32'd0);
        check("t5_rst_we", 32'({i_fill_we, i_tag_we}), 32'd0);
        check("t5_rst_data", 32'(fill_data), 32'd0);
        check("t5_rst_idx", 32'(fill_word_idx), 32'd0);
        check("t5_rst_stall", 32'(i_stall), 32'd0);
        at_cycle(7);
        #1 rst_n = 1'b1;
        stray = 0;
        for (int n = 8; n <= 20; n++) begin
            at_cycle(n);
            if (i_fill_we || i_tag_we || d_fill_we || d_tag_we || mem_en) stray++;
        end
        check("t5_no_activity_after_reset", 32'(stray), 32'd0);

        // Parameter sweep: BW=4/L=1 (I side) and BW=16/L=10 (D side).
        start_test();
        s4_i_miss_addr = 16'h0106; s4_i_miss = 1'b1;
        s16_d_miss_addr = 16'h3456; s16_d_miss = 1'b1;
        s4_iss = 0; s4_wr = 0; s4_wrong = 0; s4_tag = -1; s4_last = -1; s4_first = '0;
        s16_iss = 0; s16_wr = 0; s16_wrong = 0; s16_tag = -1; s16_last = -1; s16_first = '0;
        for (int n = 1; n <= 34; n++) begin
            at_cycle(n);
            if (s4_mem_en) begin
                if (s4_iss == 0) s4_first = s4_mem_addr;
                s4_iss++;
            end
            if (s4_i_fill_we) begin s4_wr++; s4_last = int'(s4_fill_word_idx); end
            if (s4_d_fill_we || s4_d_tag_we) s4_wrong++;
            if (s4_i_tag_we && s4_tag < 0) s4_tag = n;
            if (s16_mem_en) begin
                if (s16_iss == 0) s16_first = s16_mem_addr;
                s16_iss++;
            end
            if (s16_d_fill_we) begin s16_wr++; s16_last = int'(s16_fill_word_idx); end
            if (s16_i_fill_we || s16_i_tag_we) s16_wrong++;
            if (s16_d_tag_we && s16_tag < 0) s16_tag = n;
            #1;
            if (s4_tag > 0) s4_i_miss = 1'b0;
            if (s16_tag > 0) s16_d_miss = 1'b0;
        end
        check("s4_tag_cycle", 32'(s4_tag), 32'd5);
        check("s4_issues", 32'(s4_iss), 32'd4);
        check("s4_writes", 32'(s4_wr), 32'd4);
        check("s4_first_addr", 32'(s4_first), 32'h0100);
        check("s4_last_idx", 32'(s4_last), 32'd3);
        check("s4_wrong_channel", 32'(s4_wrong), 32'd0);
        check("s16_tag_cycle", 32'(s16_tag), 32'd26);
        check("s16_issues", 32'(s16_iss), 32'd16);
        check("s16_writes", 32'(s16_wr), 32'd16);
        check("s16_first_addr", 32'(s16_first), 32'h3440);
        check("s16_last_idx", 32'(s16_last), 32'd15);
        check("s16_wrong_channel", 32'(s16_wrong), 32'd0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
